// File: rtl/score_tracker.sv
// score_tracker: catch detector and multi-digit BCD score keeper for the snake game.
// Detects a snake-head/rabbit position match, counts each catch once, and runs a
// request/acknowledge handshake with the rabbit generator for respawn.
// Optional feature macro: SCORE_TRACKER_HIGH_EN builds the high-score register;
// without it high_bcd is tied to zero.
module score_tracker #(
    parameter int unsigned POS_W  = 8,
    parameter int unsigned DIGITS = 2,
    parameter int unsigned WRAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  game_en,
    input  logic                  score_clr,
    input  logic [POS_W-1:0]      snake_pos,
    input  logic [POS_W-1:0]      rabbit_pos,
    input  logic                  respawn_ack,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic                  respawn_req,
    output logic                  catch_pulse,
    output logic                  wrapped
);

    localparam int unsigned SW = 4 * DIGITS;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          req_q, req_d;
    logic          pulse_q, pulse_d;
    logic          wrapped_q, wrapped_d;
    logic [SW-1:0] score_q, score_d;
    logic [SW-1:0] score_inc;
    logic          all_nines;
    logic          catch_now;
    logic          hit;

    assign hit = (snake_pos == rabbit_pos) && (snake_pos != '0) && (rabbit_pos != '0);

    // Catch/handshake FSM: count once in IDLE, hold request until ack, then wait for hit to drop
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        pulse_d   = 1'b0;
        catch_now = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hit && game_en) begin
                    state_d   = ST_REQ;
                    req_d     = 1'b1;
                    pulse_d   = 1'b1;
                    catch_now = 1'b1;
                end
            end
            ST_REQ: begin
                if (respawn_ack) begin
                    state_d = ST_SETTLE;
                    req_d   = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (!hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // BCD ripple increment and all-nines detection of the current score
    always_comb begin
        logic carry;
        score_inc = score_q;
        all_nines = 1'b1;
        carry     = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (score_q[4*i +: 4] != 4'd9) begin
                all_nines = 1'b0;
            end
            if (carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    // Next score and sticky wrap flag; a clear on the same edge as a catch wins
    always_comb begin
        score_d   = score_q;
        wrapped_d = wrapped_q;
        if (score_clr) begin
            score_d   = '0;
            wrapped_d = 1'b0;
        end else if (catch_now) begin
            if (all_nines) begin
                score_d   = (WRAP != 0) ? '0 : score_q;
                wrapped_d = 1'b1;
            end else begin
                score_d = score_inc;
            end
        end
    end

    // State, score and strobe registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            pulse_q   <= 1'b0;
            wrapped_q <= 1'b0;
            score_q   <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pulse_q   <= pulse_d;
            wrapped_q <= wrapped_d;
            score_q   <= score_d;
        end
    end

`ifdef SCORE_TRACKER_HIGH_EN
    logic [SW-1:0] high_q, high_d;
    logic          next_gt;

    // Digit-wise magnitude compare, most significant digit decides first
    always_comb begin
        logic decided;
        next_gt = 1'b0;
        decided = 1'b0;
        for (int unsigned i = DIGITS; i > 0; i--) begin
            if (!decided) begin
                if (score_d[4*(i-1) +: 4] > high_q[4*(i-1) +: 4]) begin
                    next_gt = 1'b1;
                    decided = 1'b1;
                end else if (score_d[4*(i-1) +: 4] < high_q[4*(i-1) +: 4]) begin
                    decided = 1'b1;
                end
            end
        end
        high_d = next_gt ? score_d : high_q;
    end

    // High-score register tracks the next score on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            high_q <= '0;
        end else begin
            high_q <= high_d;
        end
    end

    assign high_bcd = high_q;
`else
    assign high_bcd = '0;
`endif

    assign score_bcd   = score_q;
    assign respawn_req = req_q;
    assign catch_pulse = pulse_q;
    assign wrapped     = wrapped_q;

endmodule

// File: tb/tb_score_tracker.sv
// tb_score_tracker: directed bench for score_tracker with an integer-score reference
// model. Runs a wrapping (WRAP=1) and a saturating (WRAP=0) instance on shared stimulus.
module tb_score_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       game_en = 1'b1;
    logic       score_clr = 1'b0;
    logic [7:0] snake_pos = 8'h00;
    logic [7:0] rabbit_pos = 8'h00;
    logic       respawn_ack = 1'b1;

    logic [7:0] score_w, high_w, score_s, high_s;
    logic       req_w, pulse_w, wrap_w, req_s, pulse_s, wrap_s;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    score_tracker #(.POS_W(8), .DIGITS(2), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .game_en(game_en), .score_clr(score_clr),
        .snake_pos(snake_pos), .rabbit_pos(rabbit_pos), .respawn_ack(respawn_ack),
        .score_bcd(score_w), .high_bcd(high_w), .respawn_req(req_w),
        .catch_pulse(pulse_w), .wrapped(wrap_w)
    );

    score_tracker #(.POS_W(8), .DIGITS(2), .WRAP(0)) u_sat (
        .clk(clk), .rst(rst), .game_en(game_en), .score_clr(score_clr),
        .snake_pos(snake_pos), .rabbit_pos(rabbit_pos), .respawn_ack(respawn_ack),
        .score_bcd(score_s), .high_bcd(high_s), .respawn_req(req_s),
        .catch_pulse(pulse_s), .wrapped(wrap_s)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[3:0] = 4'(v % 10);
        r[7:4] = 4'((v / 10) % 10);
        return r;
    endfunction

    // Reference model: decimal scores, handshake phase 0=waiting 1=requesting 2=settling
    int sc[2], hi[2];
    bit wr[2];
    int ph = 0;
    bit m_req = 0, m_pulse = 0, started = 0;

    always @(posedge clk) begin
        bit h, caught;
        h = (snake_pos == rabbit_pos) && (snake_pos != 0);
        caught = 0;
        started = 1;
        if (rst) begin
            ph = 0; m_req = 0; m_pulse = 0;
            for (int k = 0; k < 2; k++) begin sc[k] = 0; hi[k] = 0; wr[k] = 0; end
        end else begin
            m_pulse = 0;
            if (ph == 0 && h && game_en) begin
                caught = 1; ph = 1; m_req = 1; m_pulse = 1;
            end else if (ph == 1 && respawn_ack) begin
                ph = 2; m_req = 0;
            end else if (ph == 2 && !h) begin
                ph = 0;
            end
            for (int k = 0; k < 2; k++) begin
                if (score_clr) begin
                    sc[k] = 0; wr[k] = 0;
                end else if (caught) begin
                    if (sc[k] == 99) begin
                        wr[k] = 1;
                        sc[k] = (k == 0) ? 0 : 99;
                    end else begin
                        sc[k] = sc[k] + 1;
                    end
                end
                if (sc[k] > hi[k]) hi[k] = sc[k];
            end
        end
    end

    function automatic logic [7:0] exp_high(input int k);
`ifdef SCORE_TRACKER_HIGH_EN
        return to_bcd(hi[k]);
`else
        return 8'h00 + 8'(k * 0);
`endif
    endfunction

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            chk("score_wrap", score_w, to_bcd(sc[0]));
            chk("score_sat",  score_s, to_bcd(sc[1]));
            chk("high_wrap",  high_w,  exp_high(0));
            chk("high_sat",   high_s,  exp_high(1));
            chk("wrapped_wrap", {7'd0, wrap_w}, {7'd0, wr[0]});
            chk("wrapped_sat",  {7'd0, wrap_s}, {7'd0, wr[1]});
            chk("req_wrap",   {7'd0, req_w},   {7'd0, m_req});
            chk("req_sat",    {7'd0, req_s},   {7'd0, m_req});
            chk("pulse_wrap", {7'd0, pulse_w}, {7'd0, m_pulse});
            chk("pulse_sat",  {7'd0, pulse_s}, {7'd0, m_pulse});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One full catch: match for one edge, rabbit cleared for the ack and settle edges
    task automatic do_catch();
        respawn_ack = 1'b1;
        snake_pos = 8'h10;
        rabbit_pos = 8'h10;
        tick(1);
        rabbit_pos = 8'h00;
        tick(2);
    endtask

    logic [7:0] hi7;

    initial begin
`ifdef SCORE_TRACKER_HIGH_EN
        hi7 = 8'h07;
`else
        hi7 = 8'h00;
`endif
        // Reset state
        tick(2);
        rst = 1'b0;
        chk("lit_reset_score", score_w, 8'h00);
        chk("lit_reset_req", {7'd0, req_w}, 8'h00);
        chk("lit_reset_high", high_w, 8'h00);
        tick(1);

        // Single catch with ack tied high
        snake_pos = 8'h10; rabbit_pos = 8'h10;
        tick(1);
        chk("lit_single_score", score_w, 8'h01);
        chk("lit_single_pulse", {7'd0, pulse_w}, 8'h01);
        chk("lit_single_req", {7'd0, req_w}, 8'h01);
        tick(1);
        chk("lit_single_req_drop", {7'd0, req_w}, 8'h00);
        chk("lit_single_pulse_drop", {7'd0, pulse_w}, 8'h00);
        rabbit_pos = 8'h00;
        tick(1);

        // Held match with delayed ack
        respawn_ack = 1'b0;
        snake_pos = 8'h33; rabbit_pos = 8'h33;
        tick(5);
        chk("lit_held_req", {7'd0, req_w}, 8'h01);
        respawn_ack = 1'b1;
        tick(1);
        chk("lit_held_req_drop", {7'd0, req_w}, 8'h00);
        tick(14);
        chk("lit_held_score", score_w, 8'h02);
        rabbit_pos = 8'h00;
        tick(1);

        // Zero guard and game_en guard
        snake_pos = 8'h00; rabbit_pos = 8'h00;
        tick(3);
        game_en = 1'b0;
        snake_pos = 8'h22; rabbit_pos = 8'h22;
        tick(3);
        chk("lit_guard_score", score_w, 8'h02);
        snake_pos = 8'h00; rabbit_pos = 8'h00;
        game_en = 1'b1;
        tick(1);

        // Carry and wrap/saturate
        repeat (7) do_catch();
        chk("lit_carry_09", score_w, 8'h09);
        do_catch();
        chk("lit_carry_10", score_w, 8'h10);
        repeat (89) do_catch();
        chk("lit_max_wrap", score_w, 8'h99);
        chk("lit_max_sat", score_s, 8'h99);
        do_catch();
        chk("lit_wrap_score", score_w, 8'h00);
        chk("lit_wrap_flag", {7'd0, wrap_w}, 8'h01);
        chk("lit_sat_score", score_s, 8'h99);
        chk("lit_sat_flag", {7'd0, wrap_s}, 8'h01);

        // Reset during REQ
        respawn_ack = 1'b0;
        snake_pos = 8'h44; rabbit_pos = 8'h44;
        tick(1);
        chk("lit_inreq_req", {7'd0, req_w}, 8'h01);
        rst = 1'b1;
        tick(1);
        chk("lit_rstreq_req", {7'd0, req_w}, 8'h00);
        chk("lit_rstreq_score", score_w, 8'h00);
        chk("lit_rstreq_wrap", {7'd0, wrap_s}, 8'h00);
        rst = 1'b0;
        snake_pos = 8'h00; rabbit_pos = 8'h00;
        respawn_ack = 1'b1;
        tick(1);

        // Clear colliding with a catch
        repeat (7) do_catch();
        chk("lit_pre_clr_score", score_w, 8'h07);
        snake_pos = 8'h10; rabbit_pos = 8'h10;
        score_clr = 1'b1;
        tick(1);
        chk("lit_clr_score", score_w, 8'h00);
        chk("lit_clr_pulse", {7'd0, pulse_w}, 8'h01);
        chk("lit_clr_req", {7'd0, req_w}, 8'h01);
        chk("lit_clr_high", high_w, hi7);
        score_clr = 1'b0;
        rabbit_pos = 8'h00;
        tick(2);
        do_catch();
        chk("lit_after_clr", score_w, 8'h01);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/score_tracker.md
# score_tracker

Clocked, parametrised scoring engine for the snake game. Compares snake-head and rabbit position vectors every clock and counts each catch exactly once in a multi-digit BCD score. Runs a request/acknowledge handshake with the rabbit generator so the rabbit is reliably respawned. Sits between the movement/rabbit generators and the seven-segment display driver.

## Interface
Parameters:
- `POS_W`, default 8: width of the position vectors.
- `DIGITS`, default 2: number of BCD score digits, from 1 to 4.
- `WRAP`, default 1: at the maximum score, 1 wraps to 0 and 0 saturates.

Ports (clock and reset first):
- `clk` in, 1: system clock; all state changes on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `game_en` in, 1: catches are detected only while high.
- `score_clr` in, 1: synchronous clear of the current score (new game).
- `snake_pos` in, POS_W: one-hot or encoded snake-head position.
- `rabbit_pos` in, POS_W: rabbit position; 0 means no rabbit.
- `respawn_ack` in, 1: rabbit generator has taken the request.
- `score_bcd` out, 4*DIGITS: current score; digit 0 is in [3:0].
- `high_bcd` out, 4*DIGITS: highest score since reset.
- `respawn_req` out, 1: level request to clear and respawn the rabbit.
- `catch_pulse` out, 1: one-cycle strobe per counted catch.
- `wrapped` out, 1: sticky flag, set when the score wraps or saturates.

## Operation
- The match condition is `hit = (snake_pos == rabbit_pos) && snake_pos != 0 && rabbit_pos != 0`. It is combinational and sampled each rising edge.

State machine (3 states, encoded in 2 bits):
- IDLE:
  - If `hit && game_en`: go to REQ, raise `catch_pulse` for one cycle, increment the score, assert `respawn_req`.
  - Otherwise stay in IDLE.
- REQ:
  - `respawn_req` stays high until `respawn_ack` is sampled high.
  - Then go to SETTLE and drop `respawn_req` on that same edge.
  - `game_en` low does not abort REQ.
- SETTLE:
  - Wait until `hit` is low, then go to IDLE.
  - This guarantees one count per catch, however long the positions stay equal.

Score arithmetic:
- The score is a BCD ripple increment: a digit at 9 goes to 0 and carries into the next digit.
- At the all-nines maximum with `WRAP=1`: the score goes to 0 and `wrapped` is set.
- At the all-nines maximum with `WRAP=0`: the score holds, `wrapped` is set, and `catch_pulse` and the handshake still occur.
- `score_clr`: on the next edge the score goes to 0 and `wrapped` clears. The FSM and `high_bcd` are unaffected.
- If `score_clr` and a catch fall on the same edge, the clear wins: the score ends at 0. The catch is still acknowledged, with `catch_pulse` and `respawn_req` asserted and the FSM going to REQ.

High score:
- `high_bcd` loads the next score value whenever that value is numerically greater than `high_bcd`.
- The comparison runs digit-wise, most significant digit first.

## Timing
- Reset: all outputs 0 (`score_bcd`, `high_bcd`, `respawn_req`, `catch_pulse`, `wrapped`), and the FSM goes to IDLE.
  - This applies mid-handshake too: `respawn_req` drops on the reset edge.
- Latency: `hit` sampled at edge N gives updated `score_bcd`, `catch_pulse=1` and `respawn_req=1` after edge N.
  - `catch_pulse` is low again after edge N+1.
- `high_bcd` updates on the same edge as `score_bcd`, with no extra cycle.
- Handshake:
  - Minimum REQ duration is 1 cycle, when `respawn_ack` is already high at edge N+1.
  - `respawn_ack` is ignored outside REQ.
- Back-to-back catches need at least one cycle with `hit` low between them, via SETTLE. The minimum catch period is 3 cycles.

## Configuration
- Macro `SCORE_TRACKER_HIGH_EN`.
- Defined: the high-score register and comparator are built as described above.
- Undefined: no high-score logic is synthesised, and `high_bcd` is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- **Reset and single catch:** After reset, set `snake_pos=rabbit_pos=8'h10` with `game_en=1` and `respawn_ack` tied high. Require `score_bcd` 0x00→0x01, one `catch_pulse`, and `respawn_req` high for exactly 1 cycle.
- **Held match:** Keep the positions equal for 20 cycles, and hold `respawn_ack` low for 5 cycles. Require the score to increment once only and `respawn_req` to stay high until the ack.
- **Zero guard:** Set `snake_pos=rabbit_pos=0`. Require no count. Repeat with `game_en=0` and matching non-zero positions: again no count.
- **Carry and wrap (DIGITS=2):** Drive 100 catches. Require the score to step 0x09→0x10, reach 0x99, then go to 0x00 with `wrapped=1`. With `WRAP=0`, require it to hold at 0x99 with `wrapped=1`.
- **Clear collision and high score:** From score 0x07, assert `score_clr` on the same edge as a catch. Require score 0x00, `catch_pulse=1` and `high_bcd=0x07`. Require `high_bcd=0` when the macro is undefined.
- **Reset in REQ:** Assert `rst` while `respawn_req=1`. Require all outputs 0 on the next edge, and a fresh catch to count normally afterwards.
